// File: rtl/vote_display_ctrl.sv
// LED display controller for the N-candidate voting machine: timed flash per vote, tally display in result mode.
// Optional build macro WINNER_DISPLAY_EN: with no candidate button held in result mode, show the maximum tally.
module vote_display_ctrl #(
    parameter int NUM_CAND    = 4,
    parameter int CNT_W       = 8,
    parameter int LED_W       = 8,
    parameter int HOLD_CYCLES = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic                      any_valid_vote,
    input  logic [NUM_CAND-1:0]       cand_sel,
    input  logic [NUM_CAND*CNT_W-1:0] vote_counts,
    output logic [LED_W-1:0]          led,
    output logic                      busy
);

    localparam int TMR_W  = $clog2(HOLD_CYCLES + 1);
    localparam int WIDE_W = (CNT_W > LED_W) ? CNT_W : LED_W;
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        FLASH,
        RESULT
    } state_t;

    state_t            state;
    logic [TMR_W-1:0]  timer;
    logic              sel_any;
    logic [CNT_W-1:0]  sel_tally;
    logic [LED_W-1:0]  result_led;

    // Zero-extend narrow tallies; saturate wide ones that do not fit the LED bank.
    function automatic logic [LED_W-1:0] fit_tally(input logic [CNT_W-1:0] tally);
        logic [WIDE_W-1:0] wide;
        wide = WIDE_W'(tally);
        if (wide > WIDE_W'({LED_W{1'b1}}))
            fit_tally = '1;
        else
            fit_tally = LED_W'(wide);
    endfunction

    // Scan downward so the lowest-index pressed button is the last one assigned.
    always_comb begin
        sel_any   = 1'b0;
        sel_tally = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (cand_sel[i]) begin
                sel_any   = 1'b1;
                sel_tally = vote_counts[i*CNT_W +: CNT_W];
            end
        end
    end

`ifdef WINNER_DISPLAY_EN
    logic [CNT_W-1:0] max_tally;

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        max_tally = vote_counts[0 +: CNT_W];
        for (int i = 1; i < NUM_CAND; i++) begin
            if (vote_counts[i*CNT_W +: CNT_W] > max_tally)
                max_tally = vote_counts[i*CNT_W +: CNT_W];
        end
    end

    always_comb begin
        result_led = fit_tally(max_tally);
        if (sel_any)
            result_led = fit_tally(sel_tally);
    end
`else
    // Without a button the display holds; entering result mode with nothing held starts dark.
    always_comb begin
        result_led = (state == RESULT) ? led : '0;
        if (sel_any)
            result_led = fit_tally(sel_tally);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
            led   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mode) begin
                        state <= RESULT;
                        led   <= result_led;
                        busy  <= 1'b0;
                    end else if (any_valid_vote) begin
                        state <= FLASH;
                        timer <= HOLD_LOAD;
                        led   <= '1;
                        busy  <= 1'b1;
                    end else begin
                        led   <= '0;
                        busy  <= 1'b0;
                    end
                end
                FLASH: begin
                    if (mode) begin
                        state <= RESULT;
                        timer <= '0;
                        led   <= result_led;
                        busy  <= 1'b0;
                    end else if (any_valid_vote) begin
                        timer <= HOLD_LOAD;
                        led   <= '1;
                        busy  <= 1'b1;
                    end else if (timer <= TMR_ONE) begin
                        state <= IDLE;
                        timer <= '0;
                        led   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer - TMR_ONE;
                    end
                end
                RESULT: begin
                    busy <= 1'b0;
                    if (!mode) begin
                        state <= IDLE;
                        led   <= '0;
                    end else begin
                        led   <= result_led;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                    led   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
